// File: rtl/pll_cfg_sequencer_if.sv
// Avalon-MM management port between the PLL config sequencer and the reconfiguration block.
// The sequencer is the master; readdata carries status with a fixed one-cycle read latency.
interface pll_cfg_sequencer_if;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_writedata,
        output mgmt_write,
        output mgmt_read,
        input  mgmt_readdata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_writedata,
        input  mgmt_write,
        input  mgmt_read,
        output mgmt_readdata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_cfg_sequencer.sv
// Turns one cfg_req into the PLL reconfig write sequence (mode, N, M, C, K, start), then polls status.
// Latency: first write the cycle after acceptance; done 9+SETTLE_CYCLES cycles later at best, plus stalls and polls.
// Backpressure: waitrequest freezes the current transfer; a request while busy is dropped; TIMEOUT_CYCLES aborts.
module pll_cfg_sequencer #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       mgmt_clk,
    input  logic                       mgmt_reset_n,
    input  logic                       cfg_req,
    input  logic [17:0]                cfg_n,
    input  logic [17:0]                cfg_m,
    input  logic [17:0]                cfg_c,
    input  logic [31:0]                cfg_k,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_error,
    pll_cfg_sequencer_if.master        mgmt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    WR_LAST     = 3'd5;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_K      = 6'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_SETTLE,
        S_RD,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     wr_idx, wr_idx_nxt;
    logic [7:0]     settle_cnt, settle_cnt_nxt;
    logic [TW-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic           err_nxt;
    logic           accept;
    logic           busy;
    logic           status_done;
    logic           unused_rd_bits;

    logic [17:0]    n_q, m_q, c_q;
    logic [31:0]    k_q;

    logic [5:0]     wr_addr;
    logic [31:0]    wr_data;

    assign busy           = (state == S_WR) || (state == S_SETTLE) ||
                            (state == S_RD) || (state == S_RD_WAIT);
    assign status_done    = mgmt.mgmt_readdata[0];
    assign unused_rd_bits = ^mgmt.mgmt_readdata[31:1];

    // Write table indexed by step; order is fixed and start is always last.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (wr_idx)
            3'd0: begin wr_addr = ADDR_MODE;  wr_data = 32'd1;          end
            3'd1: begin wr_addr = ADDR_N;     wr_data = {14'd0, n_q};   end
            3'd2: begin wr_addr = ADDR_M;     wr_data = {14'd0, m_q};   end
            3'd3: begin wr_addr = ADDR_C;     wr_data = {14'd0, c_q};   end
            3'd4: begin wr_addr = ADDR_K;     wr_data = k_q;            end
            3'd5: begin wr_addr = ADDR_START; wr_data = 32'd0;          end
            default: begin wr_addr = '0;      wr_data = '0;             end
        endcase
    end

    always_comb begin
        state_nxt      = state;
        wr_idx_nxt     = wr_idx;
        settle_cnt_nxt = settle_cnt;
        tmo_cnt_nxt    = tmo_cnt;
        err_nxt        = cfg_error;
        accept         = 1'b0;

        case (state)
            S_IDLE: begin
                if (cfg_req) begin
                    accept      = 1'b1;
                    state_nxt   = S_WR;
                    wr_idx_nxt  = 3'd0;
                    tmo_cnt_nxt = '0;
                    err_nxt     = 1'b0;
                end
            end
            S_WR: begin
                if (!mgmt.mgmt_waitrequest) begin
                    if (wr_idx == WR_LAST) begin
                        state_nxt      = S_SETTLE;
                        settle_cnt_nxt = 8'd0;
                    end else begin
                        wr_idx_nxt = wr_idx + 3'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_RD;
                end else begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            S_RD: begin
                if (!mgmt.mgmt_waitrequest) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                state_nxt = status_done ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (state != S_IDLE) begin
            tmo_cnt_nxt = tmo_cnt + TW'(1);
        end

        // The counter lands on TIMEOUT_CYCLES in the same cycle the abort becomes visible.
        if (busy && (tmo_cnt == TMO_LAST)) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            state      <= S_IDLE;
            wr_idx     <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            cfg_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_idx     <= wr_idx_nxt;
            settle_cnt <= settle_cnt_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            cfg_error  <= err_nxt;
        end
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            n_q <= '0;
            m_q <= '0;
            c_q <= '0;
            k_q <= '0;
        end else if (accept) begin
            n_q <= cfg_n;
            m_q <= cfg_m;
            c_q <= cfg_c;
            k_q <= cfg_k;
        end
    end

    // Outputs decode from registered state only, so an async reset clears them at once.
    always_comb begin
        mgmt.mgmt_write     = (state == S_WR);
        mgmt.mgmt_read      = (state == S_RD);
        mgmt.mgmt_address   = '0;
        mgmt.mgmt_writedata = '0;
        if (state == S_WR) begin
            mgmt.mgmt_address   = wr_addr;
            mgmt.mgmt_writedata = wr_data;
        end else if (state == S_RD) begin
            mgmt.mgmt_address   = ADDR_STATUS;
        end
    end

    assign cfg_busy = busy;
    assign cfg_done = (state == S_DONE);

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Scoreboard bench: stimulus pushes expected Avalon transfers and events; a negedge monitor pops and compares.
module tb_pll_cfg_sequencer;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset_n;
    logic        cfg_req;
    logic [17:0] cfg_n, cfg_m, cfg_c;
    logic [31:0] cfg_k;
    logic        cfg_busy, cfg_done, cfg_error;

    always #5 mgmt_clk = ~mgmt_clk;

    pll_cfg_sequencer_if bus();

    pll_cfg_sequencer #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (40)
    ) dut (
        .mgmt_clk     (mgmt_clk),
        .mgmt_reset_n (mgmt_reset_n),
        .cfg_req      (cfg_req),
        .cfg_n        (cfg_n),
        .cfg_m        (cfg_m),
        .cfg_c        (cfg_c),
        .cfg_k        (cfg_k),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .mgmt         (bus)
    );

    localparam int EV_WR = 0, EV_RD = 1, EV_DONE = 2, EV_ERR_SET = 3, EV_ERR_CLR = 4;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [31:0] data;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];
    bit   status_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t_acc;

    always @(posedge mgmt_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Status slave: one-cycle read latency, values taken from status_q (0 once exhausted).
    logic rd_fire = 1'b0;
    always @(negedge mgmt_clk) rd_fire = mgmt_reset_n && bus.mgmt_read && !bus.mgmt_waitrequest;
    always @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) bus.mgmt_readdata <= 32'd0;
        else if (rd_fire) begin
            if (status_q.size() > 0) bus.mgmt_readdata <= {31'd0, status_q.pop_front()};
            else                     bus.mgmt_readdata <= 32'd0;
        end
    end

    task automatic push_evt(input int kind, input logic [5:0] a, input logic [31:0] d, input int stamp);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.stamp = stamp;
        exp_q.push_back(e);
    endtask

    task automatic push_writes(input logic [17:0] n, m, c, input logic [31:0] k, input int base);
        logic [5:0]  a [6];
        logic [31:0] d [6];
        a[0] = 6'd0; d[0] = 32'd1;
        a[1] = 6'd3; d[1] = {14'd0, n};
        a[2] = 6'd4; d[2] = {14'd0, m};
        a[3] = 6'd5; d[3] = {14'd0, c};
        a[4] = 6'd7; d[4] = k;
        a[5] = 6'd2; d[5] = 32'd0;
        for (int i = 0; i < 6; i++) push_evt(EV_WR, a[i], d[i], (base < 0) ? -1 : base + i);
    endtask

    task automatic push_reads(input int cnt, input int first);
        for (int i = 0; i < cnt; i++) push_evt(EV_RD, 6'd1, 32'd0, (first < 0) ? -1 : first + 2 * i);
    endtask

    task automatic expect_evt(input int kind, input logic [5:0] a, input logic [31:0] d, input int stamp);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h at cycle %0d, required nothing", kind, a, stamp);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (kind == e.kind) begin
                if (kind == EV_WR || kind == EV_RD) chk($sformatf("ev%0d_addr", kind), 64'(a), 64'(e.addr));
                if (kind == EV_WR) chk($sformatf("wr_data_a%0d", a), 64'(d), 64'(e.data));
                if (e.stamp >= 0) chk($sformatf("ev%0d_cycle", kind), 64'(stamp), 64'(e.stamp));
            end
        end
    endtask

    logic        prev_err = 1'b0, prev_stall = 1'b0, prev_w = 1'b0, prev_r = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;
    int          mon_stamp;

    always @(negedge mgmt_clk) begin
        if (!mgmt_reset_n) begin
            prev_err   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            mon_stamp = cyc + 1;
            if (prev_stall) begin
                chk("stall_addr", 64'(bus.mgmt_address), 64'(prev_a));
                chk("stall_data", 64'(bus.mgmt_writedata), 64'(prev_d));
                chk("stall_strobe", 64'({bus.mgmt_write, bus.mgmt_read}), 64'({prev_w, prev_r}));
            end
            if (cfg_error && !prev_err) begin
                expect_evt(EV_ERR_SET, 6'd0, 32'd0, mon_stamp);
                chk("abort_busy", 64'(cfg_busy), 64'd0);
                chk("abort_strobes", 64'({bus.mgmt_write, bus.mgmt_read}), 64'd0);
            end
            if (!cfg_error && prev_err) expect_evt(EV_ERR_CLR, 6'd0, 32'd0, mon_stamp);
            if (bus.mgmt_write && bus.mgmt_read) chk("both_strobes", 64'd1, 64'd0);
            if (bus.mgmt_write && !bus.mgmt_waitrequest)
                expect_evt(EV_WR, bus.mgmt_address, bus.mgmt_writedata, mon_stamp);
            if (bus.mgmt_read && !bus.mgmt_waitrequest)
                expect_evt(EV_RD, bus.mgmt_address, 32'd0, mon_stamp);
            if (cfg_done) begin
                expect_evt(EV_DONE, 6'd0, 32'd0, mon_stamp);
                chk("done_busy", 64'(cfg_busy), 64'd0);
            end
            prev_err   = cfg_error;
            prev_stall = (bus.mgmt_write || bus.mgmt_read) && bus.mgmt_waitrequest;
            prev_a     = bus.mgmt_address;
            prev_d     = bus.mgmt_writedata;
            prev_w     = bus.mgmt_write;
            prev_r     = bus.mgmt_read;
        end
    end

    task automatic do_req(input logic [17:0] n, m, c, input logic [31:0] k);
        @(posedge mgmt_clk); #1;
        cfg_n = n; cfg_m = m; cfg_c = c; cfg_k = k; cfg_req = 1'b1;
        @(posedge mgmt_clk); #1;
        cfg_req = 1'b0;
        t_acc   = cyc;
        cfg_n = 18'h3FFFF; cfg_m = 18'h3FFFF; cfg_c = 18'h3FFFF; cfg_k = 32'hFFFF_FFFF;
        chk("busy_rise", 64'(cfg_busy), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit seen_idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge mgmt_clk);
            if (!cfg_busy) begin
                seen_idle = 1'b1;
                break;
            end
        end
        chk({name, "_reached_idle"}, 64'(seen_idle), 64'd1);
        repeat (3) @(negedge mgmt_clk);
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"},  64'(cfg_busy), 64'd0);
        chk({name, "_done"},  64'(cfg_done), 64'd0);
        chk({name, "_error"}, 64'(cfg_error), 64'd0);
        chk({name, "_addr"},  64'(bus.mgmt_address), 64'd0);
        chk({name, "_wdata"}, 64'(bus.mgmt_writedata), 64'd0);
        chk({name, "_write"}, 64'(bus.mgmt_write), 64'd0);
        chk({name, "_read"},  64'(bus.mgmt_read), 64'd0);
    endtask

    localparam logic [17:0] N1 = 18'h10000, M1 = 18'h01414, C1 = 18'h00505;
    localparam logic [31:0] K1 = 32'h2000_0000;
    localparam logic [17:0] N2 = 18'h20A0B, M2 = 18'h00C0D, C2 = 18'h10102;
    localparam logic [31:0] K2 = 32'hE000_0000;

    initial begin
        mgmt_reset_n         = 1'b0;
        cfg_req              = 1'b0;
        cfg_n = '0; cfg_m = '0; cfg_c = '0; cfg_k = '0;
        bus.mgmt_waitrequest = 1'b0;

        repeat (3) @(posedge mgmt_clk); #1;
        chk_outputs_zero("reset");
        @(negedge mgmt_clk);
        mgmt_reset_n = 1'b1;

        // Nominal: two not-ready polls then ready.
        status_q = '{1'b0, 1'b0, 1'b1};
        do_req(N1, M1, C1, K1);
        push_writes(N1, M1, C1, K1, t_acc + 1);
        push_reads(3, t_acc + 11);
        push_evt(EV_DONE, 6'd0, 32'd0, t_acc + 17);
        wait_idle("nominal");

        // Three stall cycles on the M write.
        status_q = '{1'b0, 1'b0, 1'b1};
        do_req(N2, M2, C2, K2);
        push_writes(N2, M2, C2, K2, -1);
        push_reads(3, t_acc + 14);
        push_evt(EV_DONE, 6'd0, 32'd0, t_acc + 20);
        repeat (2) @(posedge mgmt_clk); #1;
        chk("stall_target_addr", 64'(bus.mgmt_address), 64'd4);
        bus.mgmt_waitrequest = 1'b1;
        repeat (3) @(posedge mgmt_clk); #1;
        bus.mgmt_waitrequest = 1'b0;
        wait_idle("stall");

        // Second request during the K write must be ignored.
        status_q = '{1'b0, 1'b1};
        do_req(N1, M1, C1, K1);
        push_writes(N1, M1, C1, K1, t_acc + 1);
        push_reads(2, t_acc + 11);
        push_evt(EV_DONE, 6'd0, 32'd0, t_acc + 15);
        repeat (4) @(posedge mgmt_clk); #1;
        chk("busy_req_at_k_write", 64'(bus.mgmt_address), 64'd7);
        cfg_n = N2; cfg_m = M2; cfg_c = C2; cfg_k = K2; cfg_req = 1'b1;
        @(posedge mgmt_clk); #1;
        cfg_req = 1'b0;
        wait_idle("busy_req");

        // Status stuck at 0: abort when the counter reaches 40.
        status_q.delete();
        do_req(N2, M2, C2, K2);
        push_writes(N2, M2, C2, K2, t_acc + 1);
        push_reads(15, t_acc + 11);
        push_evt(EV_ERR_SET, 6'd0, 32'd0, t_acc + 41);
        wait_idle("timeout");
        chk("error_sticky", 64'(cfg_error), 64'd1);

        // Ready on the first poll; the new request clears the sticky error.
        status_q = '{1'b1};
        do_req(N1, M1, C1, K1);
        push_evt(EV_ERR_CLR, 6'd0, 32'd0, t_acc + 1);
        push_writes(N1, M1, C1, K1, t_acc + 1);
        push_reads(1, t_acc + 11);
        push_evt(EV_DONE, 6'd0, 32'd0, t_acc + 13);
        wait_idle("immediate");

        // Async reset while the first status read is on the bus.
        status_q.delete();
        do_req(N2, M2, C2, K2);
        push_writes(N2, M2, C2, K2, t_acc + 1);
        repeat (10) @(posedge mgmt_clk); #1;
        chk("pre_reset_read", 64'(bus.mgmt_read), 64'd1);
        #2 mgmt_reset_n = 1'b0;
        #1 chk_outputs_zero("midpoll_reset");
        repeat (2) @(negedge mgmt_clk);
        mgmt_reset_n = 1'b1;
        chk("midpoll_queue", 64'(exp_q.size()), 64'd0);

        // Fresh request after reset completes normally.
        status_q = '{1'b0, 1'b1};
        do_req(N2, M2, C2, K2);
        push_writes(N2, M2, C2, K2, t_acc + 1);
        push_reads(2, t_acc + 11);
        push_evt(EV_DONE, 6'd0, 32'd0, t_acc + 15);
        wait_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_cfg_sequencer.md
# pll_cfg_sequencer

Avalon-MM master that programs the PLL reconfiguration register block in one request. It sits directly upstream of the reconfiguration slave's mgmt_* port. A single request pulse carrying N/M/C/K counter words becomes the full write sequence: mode, counters, start. The block then polls the status register until the reconfiguration completes and reports done, or error on timeout.

## Interface
- SETTLE_CYCLES, 4: idle cycles after the START write before the first status read (1..255).
- TIMEOUT_CYCLES, 65535: maximum cycles from request acceptance to completion before abort (≥16).
- mgmt_clk  in  1  management clock; all logic on the rising edge.
- mgmt_reset_n  in  1  asynchronous, active-low reset.
- cfg_req  in  1  single-cycle request; accepted only in IDLE.
- cfg_n  in  18  divclk word: bit17 edge, bit16 bypass, [13:8] high, [5:0] low.
- cfg_m  in  18  feedback word, same format as cfg_n.
- cfg_c  in  18  clkout0 word, same format as cfg_n.
- cfg_k  in  32  fractional word; only [31:29] are used downstream.
- cfg_busy  out  1  high from acceptance until done or error.
- cfg_done  out  1  one-cycle pulse on successful completion.
- cfg_error  out  1  sticky timeout flag; cleared on the next accepted request.
- mgmt_address  out  6  Avalon address.
- mgmt_writedata  out  32  Avalon write data.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_read  out  1  Avalon read strobe.
- mgmt_readdata  in  32  Avalon read data; fixed read latency of 1 cycle.
- mgmt_waitrequest  in  1  Avalon stall.

## Operation
- Reset: state IDLE; every output is 0, including address and writedata; timeout counter cleared.
- On acceptance, cfg_n, cfg_m, cfg_c and cfg_k are latched. Inputs are not sampled again until the next acceptance.
- States and transitions:
  - IDLE → WR when cfg_req is high.
  - WR steps through six writes (address, data):
    - (0, 1): selects polling mode, so waitrequest is low afterwards.
    - (3, {14'd0, N}).
    - (4, {14'd0, M}).
    - (5, {14'd0, C}).
    - (7, K).
    - (2, 0): start.
  - WR → SETTLE after the sixth write. SETTLE counts SETTLE_CYCLES cycles, then → RD.
  - RD drives mgmt_read with address 1. The read completes on a cycle with waitrequest low, then → RD_WAIT.
  - RD_WAIT samples mgmt_readdata[0]. If 1 → DONE; if 0 → RD.
  - DONE: pulses cfg_done, drops cfg_busy, → IDLE.
- Avalon rules:
  - While mgmt_write or mgmt_read is high and waitrequest is high, address, data and strobe hold stable.
  - A transfer completes on the edge where the strobe is high and waitrequest is low.
  - mgmt_read and mgmt_write are never high together.
- Timeout:
  - The counter starts at 0 on acceptance and increments every non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES in any state: cfg_error is set, cfg_busy is cleared, strobes drop the same cycle, and the state returns to IDLE. Dropping a stalled transfer is the defined abort behaviour.
- cfg_req while busy is ignored; there is no queueing.
- Asynchronous reset mid-sequence aborts immediately to the reset state. No cleanup write is issued.

## Timing
- Acceptance edge t: mgmt_write is high with address 0 from cycle t+1.
- With waitrequest low throughout:
  - Writes occupy t+1..t+6.
  - SETTLE occupies t+7..t+6+SETTLE_CYCLES.
  - The first read is at t+7+SETTLE_CYCLES, with RD_WAIT one cycle later.
- Each poll iteration is 2 cycles (read, then sample). No strobe is driven in RD_WAIT.
- cfg_done is high for exactly one cycle: the cycle after the RD_WAIT in which bit0 is 1. cfg_busy falls in that same cycle.
- cfg_busy rises at t+1. cfg_error clears at t+1 when a new request is accepted.
- Each waitrequest-high cycle stretches the current transfer by one cycle. The sequence order never changes.

## Test plan
- Nominal:
  - Stimulus: N=0x10000, M=0x01414, C=0x00505, K=0x20000000; waitrequest 0; status reads 0 twice, then 1; SETTLE_CYCLES=4.
  - Required: exact write order (0,1), (3,0x10000), (4,0x01414), (5,0x00505), (7,0x20000000), (2,0); three reads; cfg_done at t+17.
- Waitrequest stall:
  - Stimulus: hold waitrequest 1 for 3 cycles during the M write.
  - Required: address 4 and data stable across the stall; overall done shifted by +3 cycles.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=40; status stuck at 0.
  - Required: cfg_error=1 and busy=0 at count 40, strobes low, no done pulse; the next cfg_req clears cfg_error.
- Request while busy:
  - Stimulus: second cfg_req with different values during the K write.
  - Required: ignored; the writes use the first values; a single done pulse.
- Reset mid-poll:
  - Stimulus: mgmt_reset_n low asynchronously during RD.
  - Required: all outputs 0 immediately.
  - Then a fresh request completes normally.
- Immediate ready:
  - Stimulus: status reads 1 on the first poll.
  - Required: exactly one read; cfg_done at t+9+SETTLE_CYCLES.
